// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte producers.
// Baud select and transmit enable are only sampled between frames.
module uart_tx_arbiter #(
    parameter int NREQ       = 4,
    parameter int WR_TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tx_enable,
    input  logic [2:0]              baud_cfg,
    input  logic [NREQ-1:0]         req,
    input  logic [8*NREQ-1:0]       req_data,
    output logic [NREQ-1:0]         ack,
    output logic [7:0]              Tx_DATA,
    output logic                    Tx_WR,
    output logic                    Tx_EN,
    output logic [2:0]              baud_select,
    input  logic                    Tx_BUSY,
    output logic                    arb_busy,
    output logic [$clog2(NREQ)-1:0] last_grant,
    output logic                    timeout_err
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(WR_TIMEOUT + 1);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] ISSUE     = 2'd1;
    localparam logic [1:0] WAIT_BUSY = 2'd2;
    localparam logic [1:0] WAIT_DONE = 2'd3;

    logic [1:0]    state;
    logic [CW-1:0] wait_cnt;
    logic [IW-1:0] winner;
    logic          grant_ok;

    // Nearest pending requester after 'last'; scanning the offsets downward
    // lets the smallest offset overwrite, and offset NREQ re-grants 'last'.
    function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [IW-1:0]   last);
        logic [IW-1:0] pick;
        logic [IW-1:0] cand;
        pick = last;
        for (int k = NREQ; k >= 1; k--) begin
            cand = IW'((int'(last) + k) % NREQ);
            if (r[cand]) begin
                pick = cand;
            end
        end
        return pick;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    always_comb begin
        winner   = rr_pick(req, last_grant);
        grant_ok = tx_enable && !Tx_BUSY && (|req);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            ack         <= '0;
            Tx_WR       <= 1'b0;
            Tx_DATA     <= '0;
            Tx_EN       <= 1'b0;
            baud_select <= 3'b000;
            arb_busy    <= 1'b0;
            last_grant  <= IW'(NREQ - 1);
            timeout_err <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            ack   <= '0;
            Tx_WR <= 1'b0;
            case (state)
                IDLE: begin
                    baud_select <= baud_cfg;
                    Tx_EN       <= tx_enable;
                    if (grant_ok) begin
                        Tx_DATA    <= req_data[8*int'(winner) +: 8];
                        last_grant <= winner;
                        ack        <= onehot(winner);
                        state      <= ISSUE;
                        arb_busy   <= 1'b1;
                    end
                end
                ISSUE: begin
                    // Strobe lands one cycle after ack; the timeout window opens with it.
                    Tx_WR    <= 1'b1;
                    wait_cnt <= '0;
                    state    <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (Tx_BUSY) begin
                        state <= WAIT_DONE;
                    end else if (wait_cnt == CW'(WR_TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                        arb_busy    <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!Tx_BUSY) begin
                        state    <= IDLE;
                        arb_busy <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    arb_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a transmitter model, requester model
// and an ack/data scoreboard.
module tb_uart_tx_arbiter;

    localparam int NREQ       = 4;
    localparam int WR_TIMEOUT = 16;
    localparam int BUSY_LEN   = 20;

    logic              clk = 1'b0;
    logic              reset;
    logic              tx_enable;
    logic [2:0]        baud_cfg;
    logic [NREQ-1:0]   req = '0;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   ack;
    logic [7:0]        Tx_DATA;
    logic              Tx_WR;
    logic              Tx_EN;
    logic [2:0]        baud_select;
    logic              Tx_BUSY = 1'b0;
    logic              arb_busy;
    logic [1:0]        last_grant;
    logic              timeout_err;

    int checks = 0;
    int errors = 0;

    int want[NREQ]        = '{default: 0};
    int grants_seen[NREQ] = '{default: 0};
    int busy_mode = 0;
    int busy_left = 0;
    logic prev_wr = 1'b0;

    logic [NREQ-1:0] exp_ack_q[$];
    logic [7:0]      exp_data_q[$];
    logic [NREQ-1:0] obs_ack_q[$];
    logic [7:0]      obs_data_q[$];
    string           viol_q[$];

    uart_tx_arbiter #(.NREQ(NREQ), .WR_TIMEOUT(WR_TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .tx_enable   (tx_enable),
        .baud_cfg    (baud_cfg),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .Tx_DATA     (Tx_DATA),
        .Tx_WR       (Tx_WR),
        .Tx_EN       (Tx_EN),
        .baud_select (baud_select),
        .Tx_BUSY     (Tx_BUSY),
        .arb_busy    (arb_busy),
        .last_grant  (last_grant),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Observer, requester and transmitter models, all on the falling edge.
    always @(negedge clk) begin
        if (ack != '0) obs_ack_q.push_back(ack);
        if (Tx_WR) begin
            if (prev_wr) viol_q.push_back("wr_width");
            if (Tx_BUSY) viol_q.push_back("wr_while_busy");
            obs_data_q.push_back(Tx_DATA);
        end
        prev_wr = Tx_WR;
        for (int i = 0; i < NREQ; i++) begin
            if (ack[i]) grants_seen[i]++;
            req[i] = (want[i] > grants_seen[i]);
        end
        case (busy_mode)
            0: begin
                if (Tx_WR) busy_left = BUSY_LEN;
                else if (busy_left > 0) busy_left--;
                Tx_BUSY = (busy_left > 0);
            end
            1: begin
                busy_left = 0;
                Tx_BUSY   = 1'b0;
            end
            default: begin
                busy_left = 0;
                Tx_BUSY   = 1'b1;
            end
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_frame(input int i);
        exp_ack_q.push_back(NREQ'(1) << i);
        exp_data_q.push_back(req_data[8*i +: 8]);
    endtask

    task automatic drain(input string tag, input int limit);
        bit done = 1'b0;
        for (int c = 0; c < limit && !done; c++) begin
            @(negedge clk);
            if (obs_data_q.size() >= exp_data_q.size() && obs_ack_q.size() >= exp_ack_q.size()
                && !arb_busy && !Tx_BUSY)
                done = 1'b1;
        end
        check({tag, "_drain"}, 32'(done), 32'd1);
    endtask

    task automatic wait_busy_high(input string tag);
        bit seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            if (Tx_BUSY && arb_busy) seen = 1'b1;
        end
        check({tag, "_busy_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic score(input string tag);
        logic [NREQ-1:0] ea, oa;
        logic [7:0]      ed, od;
        while (exp_ack_q.size() > 0) begin
            ea = exp_ack_q.pop_front();
            oa = 'x;
            if (obs_ack_q.size() > 0) oa = obs_ack_q.pop_front();
            check({tag, "_ack"}, 32'(oa), 32'(ea));
        end
        check({tag, "_extra_ack"}, obs_ack_q.size(), 0);
        obs_ack_q.delete();
        while (exp_data_q.size() > 0) begin
            ed = exp_data_q.pop_front();
            od = 'x;
            if (obs_data_q.size() > 0) od = obs_data_q.pop_front();
            check({tag, "_data"}, 32'(od), 32'(ed));
        end
        check({tag, "_extra_wr"}, obs_data_q.size(), 0);
        obs_data_q.delete();
    endtask

    initial begin
        bit found;
        reset     = 1'b0;
        tx_enable = 1'b1;
        baud_cfg  = 3'b111;
        req_data  = {8'hA3, 8'h55, 8'hEA, 8'h0F};
        // All four pending through reset; requester 0 wants a second byte.
        want[0] = 2; want[1] = 1; want[2] = 1; want[3] = 1;
        expect_frame(0); expect_frame(1); expect_frame(2); expect_frame(3); expect_frame(0);

        repeat (3) @(negedge clk);
        check("rst_req", 32'(req), 32'hF);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_wr", 32'(Tx_WR), 32'h0);
        check("rst_data", 32'(Tx_DATA), 32'h0);
        check("rst_en", 32'(Tx_EN), 32'h0);
        check("rst_baud", 32'(baud_select), 32'h0);
        check("rst_busy", 32'(arb_busy), 32'h0);
        check("rst_last", 32'(last_grant), 32'h3);
        check("rst_terr", 32'(timeout_err), 32'h0);

        reset = 1'b1;
        @(negedge clk);
        check("first_ack", 32'(ack), 32'h1);
        check("first_data", 32'(Tx_DATA), 32'h0F);
        check("first_wr_early", 32'(Tx_WR), 32'h0);
        check("first_baud", 32'(baud_select), 32'h7);
        check("first_en", 32'(Tx_EN), 32'h1);
        check("first_arb_busy", 32'(arb_busy), 32'h1);
        @(negedge clk);
        check("first_wr", 32'(Tx_WR), 32'h1);
        check("first_ack_gone", 32'(ack), 32'h0);
        check("first_data_hold", 32'(Tx_DATA), 32'h0F);
        drain("rr", 400);
        score("rr");
        check("rr_last", 32'(last_grant), 32'h0);

        want[1]++; expect_frame(1);
        drain("single1", 100);
        score("single1");
        check("single1_last", 32'(last_grant), 32'h1);

        // last_grant=1 with 0 and 1 pending: wrap to 0 first.
        want[0]++; want[1]++; expect_frame(0); expect_frame(1);
        drain("wrap", 200);
        score("wrap");

        want[1]++; expect_frame(1);
        drain("regrant", 100);
        score("regrant");
        check("regrant_last", 32'(last_grant), 32'h1);

        want[2]++; expect_frame(2);
        wait_busy_high("cfg");
        baud_cfg  = 3'b010;
        tx_enable = 1'b0;
        want[3]++;
        repeat (5) @(negedge clk);
        check("cfg_baud_held", 32'(baud_select), 32'h7);
        check("cfg_en_held", 32'(Tx_EN), 32'h1);
        check("cfg_in_frame", 32'(arb_busy), 32'h1);
        found = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            @(negedge clk);
            if (!arb_busy) found = 1'b1;
        end
        check("cfg_idle_seen", 32'(found), 32'h1);
        repeat (2) @(negedge clk);
        check("cfg_baud_new", 32'(baud_select), 32'h2);
        check("cfg_en_new", 32'(Tx_EN), 32'h0);
        repeat (20) @(negedge clk);
        check("cfg_no_grant_busy", 32'(arb_busy), 32'h0);
        check("cfg_req_pending", 32'(req[3]), 32'h1);
        score("cfg");
        expect_frame(3);
        tx_enable = 1'b1;
        baud_cfg  = 3'b111;
        drain("reenable", 100);
        score("reenable");

        busy_mode = 1;
        want[0]++; expect_frame(0);
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (Tx_WR) found = 1'b1;
        end
        check("to_wr_seen", 32'(found), 32'h1);
        repeat (WR_TIMEOUT - 1) @(negedge clk);
        check("to_still_waiting", 32'(arb_busy), 32'h1);
        check("to_not_yet", 32'(timeout_err), 32'h0);
        @(negedge clk);
        check("to_back_idle", 32'(arb_busy), 32'h0);
        check("to_err_set", 32'(timeout_err), 32'h1);
        repeat (10) @(negedge clk);
        check("to_err_sticky", 32'(timeout_err), 32'h1);
        score("timeout");

        // External busy while idle must hold off grants.
        busy_mode = 2;
        repeat (2) @(negedge clk);
        want[1]++;
        repeat (10) @(negedge clk);
        check("ext_busy_no_grant", 32'(arb_busy), 32'h0);
        score("ext_busy");
        expect_frame(1);
        busy_mode = 0;
        drain("ext_release", 100);
        score("ext_release");
        check("ext_err_sticky", 32'(timeout_err), 32'h1);

        want[2]++; expect_frame(2);
        wait_busy_high("midrst");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_arb_busy", 32'(arb_busy), 32'h0);
        check("midrst_en", 32'(Tx_EN), 32'h0);
        check("midrst_last", 32'(last_grant), 32'h3);
        check("midrst_terr", 32'(timeout_err), 32'h0);
        check("midrst_wr", 32'(Tx_WR), 32'h0);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        score("midrst");
        check("midrst_req_clear", 32'(req), 32'h0);
        check("protocol_viol", viol_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
